// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared constants for the EX-stage divider sequencer.
// Holds the sequencer state encodings and the start/stall level names that
// the divider and the pipeline controller also understand.
package div_ctrl_pkg;

   // Sequencer states (2-bit, legacy-compatible encodings)
   localparam logic [1:0] DIV_CTRL_IDLE  = 2'b00;
   localparam logic [1:0] DIV_CTRL_BUSY  = 2'b01;
   localparam logic [1:0] DIV_CTRL_DRAIN = 2'b10;

   // Divider start_i levels
   localparam logic DIV_START = 1'b1;
   localparam logic DIV_STOP  = 1'b0;

   // Pipeline stall request levels
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // True when a divisor is zero, used by the optional by-zero bypass
   function automatic logic is_zero_divisor(input logic [63:0] divisor);
      return (divisor == 64'd0);
   endfunction

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: sequences the shared iterative radix-4 divider for DIV/DIVU in EX.
// Launches the divider with registered operands, stalls the pipeline until
// div_ready_i, writes {HI,LO} with a one-cycle strobe, and on a flush drains
// the divider without writing.
// Optional feature: define DIV_ZERO_BYPASS_EN to answer divide-by-zero
// directly from IDLE with {0,0} instead of launching the divider.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DW = 32
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_div_req_i,
   input  logic            ex_signed_i,
   input  logic [DW-1:0]   ex_op1_i,
   input  logic [DW-1:0]   ex_op2_i,
   input  logic            flush_i,
   output logic            stall_req_o,
   output logic            hilo_we_o,
   output logic [DW-1:0]   hi_o,
   output logic [DW-1:0]   lo_o,
   output logic            busy_o,
   output logic            div_signed_o,
   output logic [DW-1:0]   div_op1_o,
   output logic [DW-1:0]   div_op2_o,
   output logic            div_start_o,
   input  logic [2*DW-1:0] div_result_i,
   input  logic            div_ready_i
);

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic [DW-1:0] op1_q;
   logic [DW-1:0] op2_q;
   logic          signed_q;
   logic          launch;
   logic          bypass;

   // Decide whether this cycle launches the divider or answers a by-zero divide directly
   always_comb begin
      bypass = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      bypass = (state == DIV_CTRL_IDLE) && ex_div_req_i && !flush_i &&
               is_zero_divisor(64'(ex_op2_i));
`endif
      launch = (state == DIV_CTRL_IDLE) && ex_div_req_i && !flush_i && !bypass;
   end

   // Mealy outputs and next state from the current state plus EX/divider inputs
   always_comb begin
      state_next   = state;
      stall_req_o  = NO_STOP;
      hilo_we_o    = 1'b0;
      hi_o         = '0;
      lo_o         = '0;
      div_start_o  = DIV_STOP;
      div_signed_o = signed_q;
      div_op1_o    = op1_q;
      div_op2_o    = op2_q;
      case (state)
         DIV_CTRL_IDLE: begin
            if (launch) begin
               div_start_o  = DIV_START;
               div_signed_o = ex_signed_i;
               div_op1_o    = ex_op1_i;
               div_op2_o    = ex_op2_i;
               stall_req_o  = STOP;
               state_next   = DIV_CTRL_BUSY;
            end else if (bypass) begin
               hilo_we_o = 1'b1;
            end
         end
         DIV_CTRL_BUSY: begin
            if (!div_ready_i) begin
               div_start_o = DIV_START;
               stall_req_o = STOP;
               if (flush_i) begin
                  state_next = DIV_CTRL_DRAIN;
               end
            end else begin
               state_next = DIV_CTRL_IDLE;
               if (!flush_i) begin
                  hilo_we_o    = 1'b1;
                  {hi_o, lo_o} = div_result_i;
               end
            end
         end
         DIV_CTRL_DRAIN: begin
            stall_req_o = ex_div_req_i ? STOP : NO_STOP;
            if (!div_ready_i) begin
               div_start_o = DIV_START;
            end else begin
               state_next = DIV_CTRL_IDLE;
            end
         end
         default: begin
            state_next = DIV_CTRL_IDLE;
         end
      endcase
   end

   // State register and operand latch, captured on launch and held until release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= DIV_CTRL_IDLE;
         op1_q    <= '0;
         op2_q    <= '0;
         signed_q <= 1'b0;
      end else begin
         state <= state_next;
         if (launch) begin
            op1_q    <= ex_op1_i;
            op2_q    <= ex_op2_i;
            signed_q <= ex_signed_i;
         end
      end
   end

   assign busy_o = (state != DIV_CTRL_IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl.
// Contains a behavioural stand-in for the radix-4 divider (20-cycle result,
// 3-cycle by-zero answer, ready held while start stays high) and checks the
// sequencer's start/stall/write behaviour against plain-arithmetic results.
// Honours DIV_ZERO_BYPASS_EN when the design is built with it.
module tb_div_ctrl;

   logic        clk;
   logic        rst;
   logic        exDivReq;
   logic        exSigned;
   logic [31:0] exOp1;
   logic [31:0] exOp2;
   logic        flush;
   logic        stallReq;
   logic        hiloWe;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        divSigned;
   logic [31:0] divOp1;
   logic [31:0] divOp2;
   logic        divStart;
   logic [63:0] divResult;
   logic        divReady;

   int tests = 0;
   int fails = 0;

   div_ctrl #(.DW(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_div_req_i (exDivReq),
      .ex_signed_i  (exSigned),
      .ex_op1_i     (exOp1),
      .ex_op2_i     (exOp2),
      .flush_i      (flush),
      .stall_req_o  (stallReq),
      .hilo_we_o    (hiloWe),
      .hi_o         (hi),
      .lo_o         (lo),
      .busy_o       (busy),
      .div_signed_o (divSigned),
      .div_op1_o    (divOp1),
      .div_op2_o    (divOp2),
      .div_start_o  (divStart),
      .div_result_i (divResult),
      .div_ready_i  (divReady)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute time limit so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Architectural DIV/DIVU result: {remainder, quotient}, truncating; by-zero gives 0
   function automatic logic [63:0] refDiv(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   // Behavioural divider: ready 20 cycles after launch (3 for by-zero), held until start drops
   logic        dvActive;
   int          dvCount;
   logic [63:0] dvResult;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         dvActive <= 1'b0;
         dvCount  <= 0;
         dvResult <= '0;
      end else if (!dvActive) begin
         if (divStart) begin
            dvActive <= 1'b1;
            dvCount  <= (divOp2 == 32'd0) ? 2 : 19;
            dvResult <= refDiv(divSigned, divOp1, divOp2);
         end
      end else if (!divStart) begin
         dvActive <= 1'b0;
      end else if (dvCount > 0) begin
         dvCount <= dvCount - 1;
      end
   end

   assign divReady  = dvActive && (dvCount == 0);
   assign divResult = divReady ? dvResult : 64'd0;

   // One comparison: counts it, and reports observed/expected on mismatch
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive the EX-side inputs
   task automatic applyStimulus(input logic req, input logic s, input logic [31:0] a,
                                input logic [31:0] b, input logic fl);
      exDivReq = req;
      exSigned = s;
      exOp1    = a;
      exOp2    = b;
      flush    = fl;
   endtask

   // Advance to just after the next rising edge, where inputs are driven
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one divide in the next cycle and check it to completion
   task automatic runDivide(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [63:0] expRes;
      int          lat;
      expRes = refDiv(s, a, b);
      lat    = (b == 32'd0) ? 3 : 20;
`ifdef DIV_ZERO_BYPASS_EN
      if (b == 32'd0) lat = 0;
`endif
      nextCycle();
      applyStimulus(1'b1, s, a, b, 1'b0);
      for (int cyc = 0; cyc <= lat; cyc++) begin
         @(negedge clk);
         if (cyc < lat) begin
            checkOutput($sformatf("%s start c%0d", tag, cyc), divStart, 1);
            checkOutput($sformatf("%s stall c%0d", tag, cyc), stallReq, 1);
            checkOutput($sformatf("%s we c%0d", tag, cyc), hiloWe, 0);
            checkOutput($sformatf("%s op1 c%0d", tag, cyc), divOp1, a);
            checkOutput($sformatf("%s op2 c%0d", tag, cyc), divOp2, b);
            checkOutput($sformatf("%s sgn c%0d", tag, cyc), divSigned, s);
            checkOutput($sformatf("%s busy c%0d", tag, cyc), busy, (cyc != 0));
            nextCycle();
         end else begin
            checkOutput($sformatf("%s we done", tag), hiloWe, 1);
            checkOutput($sformatf("%s hilo done", tag), {hi, lo}, expRes);
            checkOutput($sformatf("%s stall done", tag), stallReq, 0);
            checkOutput($sformatf("%s start done", tag), divStart, 0);
            checkOutput($sformatf("%s busy done", tag), busy, (lat != 0));
         end
      end
   endtask

   // Drop the request in the next cycle and check that the block is quiet
   task automatic goIdle(input string tag);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("%s idle stall", tag), stallReq, 0);
      checkOutput($sformatf("%s idle we", tag), hiloWe, 0);
      checkOutput($sformatf("%s idle hilo", tag), {hi, lo}, 64'd0);
   endtask

   initial begin
      logic        rs;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        expStall;

      // Reset state
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      #12;
      checkOutput("reset stall", stallReq, 0);
      checkOutput("reset start", divStart, 0);
      checkOutput("reset we", hiloWe, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset hilo", {hi, lo}, 64'd0);
      checkOutput("reset ops", {divSigned, divOp1, divOp2}, 65'd0);
      @(negedge clk);
      rst = 1'b1;

      // DIVU 100/7: 20-cycle latency, lo=14 hi=2
      runDivide(1'b0, 32'd100, 32'd7, "divu100_7");
      checkOutput("divu100_7 lo", lo, 32'd14);
      checkOutput("divu100_7 hi", hi, 32'd2);
      goIdle("divu100_7");

      // Signed divides with negative operands
      runDivide(1'b1, 32'hFFFF_FFF9, 32'd2, "div-7_2");
      checkOutput("div-7_2 lo", lo, 32'hFFFF_FFFD);
      checkOutput("div-7_2 hi", hi, 32'hFFFF_FFFF);
      goIdle("div-7_2");
      runDivide(1'b1, 32'd7, 32'hFFFF_FFFE, "div7_-2");
      checkOutput("div7_-2 lo", lo, 32'hFFFF_FFFD);
      checkOutput("div7_-2 hi", hi, 32'd1);
      goIdle("div7_-2");

      // Flush at cycle 5 of DIVU 50/6: drain, no write, new divide waits then launches
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'd50, 32'd6, 1'b0);
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         checkOutput($sformatf("flush pre start c%0d", cyc), divStart, 1);
         nextCycle();
      end
      applyStimulus(1'b0, 1'b0, 32'd50, 32'd6, 1'b1);
      @(negedge clk);
      checkOutput("flush c5 start", divStart, 1);
      checkOutput("flush c5 we", hiloWe, 0);
      for (int cyc = 6; cyc <= 20; cyc++) begin
         nextCycle();
         if (cyc == 9) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
         else          applyStimulus(1'b1, 1'b0, 32'd77, 32'd8, 1'b0);
         expStall = (cyc != 9);
         @(negedge clk);
         checkOutput($sformatf("drain we c%0d", cyc), hiloWe, 0);
         checkOutput($sformatf("drain stall c%0d", cyc), stallReq, expStall);
         checkOutput($sformatf("drain start c%0d", cyc), divStart, (cyc < 20));
         checkOutput($sformatf("drain busy c%0d", cyc), busy, 1);
      end
      runDivide(1'b0, 32'd77, 32'd8, "after_drain");
      goIdle("after_drain");

      // Back-to-back DIVUs 12/5 then 9/3
      runDivide(1'b0, 32'd12, 32'd5, "b2b_first");
      checkOutput("b2b_first hilo", {hi, lo}, {32'd2, 32'd2});
      runDivide(1'b0, 32'd9, 32'd3, "b2b_second");
      checkOutput("b2b_second hilo", {hi, lo}, {32'd0, 32'd3});
      goIdle("b2b");

      // Divide by zero (bypass or 3-cycle divider path)
      runDivide(1'b0, 32'd5, 32'd0, "divu5_0");
      goIdle("divu5_0");

      // Asynchronous reset at cycle 10 of a divide
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'd1000, 32'd3, 1'b0);
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         nextCycle();
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async rst stall", stallReq, 0);
      checkOutput("async rst start", divStart, 0);
      checkOutput("async rst busy", busy, 0);
      checkOutput("async rst we", hiloWe, 0);
      checkOutput("async rst hilo", {hi, lo}, 64'd0);
      checkOutput("async rst ops", {divSigned, divOp1, divOp2}, 65'd0);
      @(negedge clk);
      rst = 1'b1;
      runDivide(1'b0, 32'd9, 32'd4, "post_rst");
      checkOutput("post_rst hilo", {hi, lo}, {32'd1, 32'd2});
      goIdle("post_rst");

      // Randomized DIV/DIVU against the arithmetic reference
      for (int n = 0; n < 12; n++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         if ($urandom_range(0, 7) == 0)      rb = 32'd0;
         else if ($urandom_range(0, 1) == 1) rb = $urandom;
         else                                rb = 32'($urandom_range(1, 100));
         if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
         runDivide(rs, ra, rb, $sformatf("rand%0d", n));
         if ($urandom_range(0, 1) == 1) goIdle($sformatf("rand%0d", n));
      end
      goIdle("final");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
